dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences 32-bit load/store requests from the pipeline's memory stage onto the byte-wide data memory array. Splits each word access into byte beats and reassembles read data (big-endian). Applies alignment and range checks and reports completion with a one-cycle response pulse. Sits between the MEM stage (stall on !req_ready) and the byte memory.

Parameters:
MEM_BYTES, 256, number of bytes in the data memory array
ADDR_W, 8, width of mem_addr; must satisfy 2**ADDR_W >= MEM_BYTES

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present; sampled only when req_ready=1
req_write  in  1  1=store, 0=load
req_size  in  1  0=byte, 1=word
req_signed  in  1  byte loads only: 1=sign-extend, 0=zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data; byte stores use bits [7:0]
req_ready  out  1  controller idle, can accept a request
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: access rejected, no memory activity
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
mem_addr  out  ADDR_W  byte address to memory
mem_wdata  out  8  byte write data
mem_we  out  1  byte write strobe
mem_re  out  1  byte read strobe; mem_rdata is valid in the following cycle
mem_rdata  in  8  byte read data (synchronous-read memory)

Behaviour:
- All outputs are registered except req_ready, which is decoded from state (=1 iff IDLE).
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0. Asserting reset mid-access aborts it: no strobe after the reset edge, no response, and bytes already written stay written.
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE: on req_valid at edge T, latch the request. Check: word requires req_addr[1:0]==0. Range requires req_addr + nbytes <= MEM_BYTES (nbytes = 4 or 1, computed without 32-bit overflow). A failed check goes to RESP with err=1, so resp_valid=1 and resp_err=1 in cycle T+1, with no strobes. Otherwise go to ACCESS.
- ACCESS: one beat per cycle, k=0..nbytes-1, in cycles T+1..T+nbytes. mem_addr = base+k. Store: mem_we=1, mem_wdata = wdata[31-8k -: 8] for word, wdata[7:0] for byte. Load: mem_re=1. Exactly one of mem_we/mem_re is high per beat; both are 0 outside ACCESS.
- Load data capture: mem_rdata sampled in the cycle after each mem_re beat, into byte lane k of the assembly register (beat 0 goes to [31:24]).
- After the last beat, a store goes to RESP and a load goes to DRAIN. DRAIN lasts one cycle and captures the last byte, then goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No back-pressure on the response.
- Latency from accept edge T to the resp_valid cycle: word store T+5, byte store T+2, word load T+6, byte load T+3, error T+1.
- Byte load result is {24{sign},byte}. The sign bit is byte[7] when req_signed=1, else 0.
- Requests presented while req_ready=0 are ignored and not queued. The requester must hold them until accepted.
- A new request can be accepted in the IDLE cycle immediately after RESP. There is no overlap between accesses.

Decomposition:
- Package dmem_pkg: state enum (IDLE, ACCESS, DRAIN, RESP), size codes SZ_BYTE=0/SZ_WORD=1, BYTES_PER_WORD=4.
- Single flat module; no sub-module is warranted. The byte-lane select and assembly logic stay inline.

Test Plan:
- Word store 0xDEADBEEF to 0x10, accepted at edge T: mem_we cycles T+1..T+4 write 0x10=DE, 0x11=AD, 0x12=BE, 0x13=EF. resp_valid=1, resp_err=0 at T+5. req_ready=0 from T+1 through T+5.
- Word load from 0x10 after the store above: four mem_re beats at addresses 0x10..0x13. resp_valid at T+6 with resp_rdata=0xDEADBEEF.
- Byte load from 0x11, signed: resp_rdata=0xFFFFFFAD at T+3. The same load unsigned returns 0x000000AD. A byte store of 0x5A to 0x13 gives one mem_we beat and resp at T+2, and a following word load from 0x10 returns 0xDEADBE5A.
- Misaligned word load at 0x12, and a word store at 0xFE with MEM_BYTES=256: resp_valid and resp_err=1 at T+1, resp_rdata=0, and mem_we/mem_re never asserted.
- Reset asserted for one cycle at T+3 during a word store of 0x11223344 to 0x20: only 0x20=11 and 0x21=22 are written. No strobes and no resp_valid after the reset edge. req_ready=1 once reset deasserts.
- req_valid toggled with different requests while busy: none are accepted. The request held at the first IDLE cycle is accepted and completes with correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory access controller
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic SZ_BYTE        = 1'b0;
    localparam logic SZ_WORD        = 1'b1;
    localparam int   BYTES_PER_WORD = 4;

    // Big-endian lane select: lane 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences word/byte load-store requests onto a byte-wide data memory
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                write_q, write_d;
    logic                size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         asm_q, asm_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;

    logic [32:0]         req_end;
    logic                req_ok;
    logic                is_last;
    logic [1:0]          next_beat;

    // 33-bit end address keeps the range check free of 32-bit wraparound.
    assign req_end   = {1'b0, req_addr} + ((req_size == SZ_WORD) ? 33'(BYTES_PER_WORD) : 33'd1);
    assign req_ok    = !((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                       && (req_end <= 33'(MEM_BYTES));
    assign is_last   = (size_q == SZ_BYTE) || (beat_q == 2'd3);
    assign next_beat = beat_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    base_d   = req_addr[ADDR_W-1:0];
                    wdata_d  = req_wdata;
                    asm_d    = 32'd0;
                    beat_d   = 2'd0;
                    if (req_ok) begin
                        state_d     = ACCESS;
                        mem_addr_d  = req_addr[ADDR_W-1:0];
                        mem_wdata_d = (req_size == SZ_WORD) ? req_wdata[31:24] : req_wdata[7:0];
                        mem_we_d    = req_write;
                        mem_re_d    = !req_write;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Read data for the previous beat arrives one cycle after its strobe.
                if (!write_q) begin
                    case (beat_q)
                        2'd1:    asm_d[31:24] = mem_rdata;
                        2'd2:    asm_d[23:16] = mem_rdata;
                        2'd3:    asm_d[15:8]  = mem_rdata;
                        default: ;
                    endcase
                end
                if (!is_last) begin
                    beat_d      = next_beat;
                    mem_addr_d  = base_q + ADDR_W'(next_beat);
                    mem_wdata_d = word_byte(wdata_q, next_beat);
                    mem_we_d    = write_q;
                    mem_re_d    = !write_q;
                end else if (write_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = (size_q == SZ_WORD) ? {asm_q[31:8], mem_rdata}
                                                   : {{24{signed_q & mem_rdata[7]}}, mem_rdata};
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            base_q       <= '0;
            wdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_size = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  bmem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    dmem_access_ctrl #(.MEM_BYTES(256), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read byte memory
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= bmem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {bmem[a], bmem[a+1], bmem[a+2], bmem[a+3]};
    endfunction

    // Present a request at a falling edge and hold it until it is accepted.
    task automatic issue(input logic w, input logic sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bit accepted = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Observe cycles T+1.. after the accept edge until resp_valid.
    task automatic wait_resp(input string tag, input int exp_lat, input logic exp_err,
                             input logic [31:0] exp_rdata, input int exp_we, input int exp_re,
                             input logic [7:0] exp_addr0);
        int lat = 0, nwe = 0, nre = 0, nrdy = 0;
        logic [7:0] addr0 = 8'd0;
        logic got_err = 1'b0;
        logic [31:0] got_rdata = 32'd0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (req_ready) nrdy++;
            if ((mem_we || mem_re) && (nwe + nre == 0)) addr0 = mem_addr;
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (resp_valid) begin
                lat = n; got_err = resp_err; got_rdata = resp_rdata;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_nwe"}, nwe, exp_we);
        check({tag, "_nre"}, nre, exp_re);
        check({tag, "_ready_busy"}, nrdy, 0);
        if (nwe + nre > 0) check({tag, "_addr0"}, {24'd0, addr0}, {24'd0, exp_addr0});
    endtask

    initial begin
        int nstb, nrv, nrdy0;
        for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
        bmem[255] = 8'h80;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);

        issue(1, 1, 0, 32'h10, 32'hDEADBEEF);
        wait_resp("wst", 5, 0, 32'h0, 4, 0, 8'h10);
        check("wst_mem", word_at(16), 32'hDEADBEEF);

        issue(0, 1, 0, 32'h10, 32'h0);
        wait_resp("wld", 6, 0, 32'hDEADBEEF, 0, 4, 8'h10);
        issue(0, 0, 1, 32'h11, 32'h0);
        wait_resp("bld_s", 3, 0, 32'hFFFFFFAD, 0, 1, 8'h11);
        issue(0, 0, 0, 32'h11, 32'h0);
        wait_resp("bld_u", 3, 0, 32'h000000AD, 0, 1, 8'h11);

        issue(1, 0, 0, 32'h13, 32'hFFFFFF5A);
        wait_resp("bst", 2, 0, 32'h0, 1, 0, 8'h13);
        issue(0, 1, 0, 32'h10, 32'h0);
        wait_resp("wld2", 6, 0, 32'hDEADBE5A, 0, 4, 8'h10);

        issue(0, 1, 0, 32'h12, 32'h0);
        wait_resp("misalign", 1, 1, 32'h0, 0, 0, 8'h00);
        issue(1, 1, 0, 32'hFE, 32'h12345678);
        wait_resp("range_wst", 1, 1, 32'h0, 0, 0, 8'h00);
        issue(0, 0, 0, 32'h100, 32'h0);
        wait_resp("range_bld", 1, 1, 32'h0, 0, 0, 8'h00);
        issue(0, 1, 0, 32'hFFFFFFFC, 32'h0);
        wait_resp("range_wrap", 1, 1, 32'h0, 0, 0, 8'h00);
        issue(0, 1, 0, 32'hFC, 32'h0);
        wait_resp("edge_wld", 6, 0, 32'h00000080, 0, 4, 8'hFC);
        issue(0, 0, 1, 32'hFF, 32'h0);
        wait_resp("edge_bld", 3, 0, 32'hFFFFFF80, 0, 1, 8'hFF);

        // Reset during a word store: the edge starting T+3 sees reset.
        issue(1, 1, 0, 32'h20, 32'h11223344);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nstb = 0; nrv = 0; nrdy0 = 0;
        for (int n = 0; n < 10; n++) begin
            if (mem_we || mem_re) nstb++;
            if (resp_valid) nrv++;
            if (!req_ready) nrdy0++;
            @(negedge clk);
        end
        check("rstmid_strobes", nstb, 0);
        check("rstmid_resp", nrv, 0);
        check("rstmid_ready", nrdy0, 0);
        check("rstmid_mem", word_at(32), 32'h11220000);

        // Requests toggled while busy must be ignored.
        issue(1, 1, 0, 32'h40, 32'hCAFEF00D);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            req_valid = n[0]; req_write = 1'b1; req_size = 1'b0;
            req_addr = 32'h80 + n; req_wdata = 32'hA0 + n;
        end
        @(negedge clk);
        check("busy_resp_t5", {31'd0, resp_valid}, 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 1'b0; req_signed = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h00000077;
        @(negedge clk);
        check("busy_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp("held_bst", 2, 0, 32'h0, 1, 0, 8'h50);
        check("busy_word", word_at(64), 32'hCAFEF00D);
        check("busy_decoys", word_at(129), 32'h0);
        check("held_mem", {24'd0, bmem[80]}, 32'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
